// File: rtl/pid_error_core.sv
// PID error core: error/integral/derivative products, full-precision sum saturated to OUT_WIDTH; 3-cycle strobe latency, no backpressure.
// Define PID_DERIV_ON_MEAS_EN to take the derivative on the measurement instead of the error.
module pid_error_core #(
  parameter int IN_WIDTH   = 16,
  parameter int GAIN_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 40
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         in_strobe,
  input  logic signed [IN_WIDTH-1:0]   sample,
  input  logic signed [IN_WIDTH-1:0]   setpoint,
  input  logic signed [GAIN_WIDTH-1:0] kp,
  input  logic signed [GAIN_WIDTH-1:0] ki,
  input  logic signed [GAIN_WIDTH-1:0] kd,
  input  logic                         integ_clear,
  input  logic                         integ_hold,
  output logic                         out_strobe,
  output logic signed [OUT_WIDTH-1:0]  pid_out
);

  localparam int EW   = IN_WIDTH + 1;
  localparam int DW   = IN_WIDTH + 2;
  localparam int AW1  = ACC_WIDTH + 1;
  localparam int PPW  = GAIN_WIDTH + EW;
  localparam int PIW  = GAIN_WIDTH + ACC_WIDTH;
  localparam int PDW  = GAIN_WIDTH + DW;
  localparam int MAXP = (PIW > PPW) ? ((PIW > PDW) ? PIW : PDW) : ((PPW > PDW) ? PPW : PDW);
  localparam int SUMW = MAXP + 2;
  localparam int CW   = (SUMW > OUT_WIDTH) ? SUMW : OUT_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ~ACC_MAX;
  localparam logic signed [CW-1:0]        OUT_MAX = (CW'(1) << (OUT_WIDTH-1)) - CW'(1);
  localparam logic signed [CW-1:0]        OUT_MIN = ~OUT_MAX;

  logic signed [EW-1:0]         error;
  logic signed [DW-1:0]         diff;
  logic signed [AW1-1:0]        acc_sum;
  logic signed [ACC_WIDTH-1:0]  acc_next;
  logic signed [ACC_WIDTH-1:0]  acc;

  logic                         vld1, vld2;
  logic signed [EW-1:0]         err_s1;
  logic signed [DW-1:0]         diff_s1;
  logic signed [GAIN_WIDTH-1:0] kp_s1, ki_s1, kd_s1;
  logic signed [PPW-1:0]        prod_p;
  logic signed [PIW-1:0]        prod_i;
  logic signed [PDW-1:0]        prod_d;
  logic signed [SUMW-1:0]       sum;
  logic signed [CW-1:0]         sum_c;
  logic signed [OUT_WIDTH-1:0]  sat;

  assign error = EW'(setpoint) - EW'(sample);

`ifdef PID_DERIV_ON_MEAS_EN
  logic signed [IN_WIDTH-1:0] prev_sample;
  assign diff = DW'(prev_sample) - DW'(sample);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       prev_sample <= '0;
    else if (in_strobe) prev_sample <= sample;
  end
`else
  logic signed [EW-1:0] prev_error;
  assign diff = DW'(error) - DW'(prev_error);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       prev_error <= '0;
    else if (in_strobe) prev_error <= error;
  end
`endif

  // Integrator saturates instead of wrapping so a long error run cannot flip its sign.
  always_comb begin
    acc_sum  = AW1'(acc) + AW1'(error);
    acc_next = acc_sum[ACC_WIDTH-1:0];
    if (acc_sum[ACC_WIDTH] != acc_sum[ACC_WIDTH-1])
      acc_next = acc_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  always_comb begin
    sum   = SUMW'(prod_p) + SUMW'(prod_i) + SUMW'(prod_d);
    sum_c = CW'(sum);
    sat   = sum_c[OUT_WIDTH-1:0];
    if (sum_c > OUT_MAX)      sat = OUT_MAX[OUT_WIDTH-1:0];
    else if (sum_c < OUT_MIN) sat = OUT_MIN[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld1       <= 1'b0;
      vld2       <= 1'b0;
      out_strobe <= 1'b0;
      err_s1     <= '0;
      diff_s1    <= '0;
      kp_s1      <= '0;
      ki_s1      <= '0;
      kd_s1      <= '0;
      acc        <= '0;
      prod_p     <= '0;
      prod_i     <= '0;
      prod_d     <= '0;
      pid_out    <= '0;
    end else begin
      vld1       <= in_strobe;
      vld2       <= vld1;
      out_strobe <= vld2;
      if (in_strobe) begin
        err_s1  <= error;
        diff_s1 <= diff;
        kp_s1   <= kp;
        ki_s1   <= ki;
        kd_s1   <= kd;
      end
      if (integ_clear)                   acc <= '0;
      else if (in_strobe && !integ_hold) acc <= acc_next;
      // Stage 2 reads acc after this strobe's update; a following strobe's update lands on the same edge.
      if (vld1) begin
        prod_p <= PPW'(kp_s1) * PPW'(err_s1);
        prod_i <= PIW'(ki_s1) * PIW'(acc);
        prod_d <= PDW'(kd_s1) * PDW'(diff_s1);
      end
      if (vld2) pid_out <= sat;
    end
  end

endmodule

// File: tb/tb_pid_error_core.sv
module tb_pid_error_core;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               in_strobe = 1'b0;
  logic signed [15:0] sample = '0, setpoint = '0;
  logic signed [15:0] kp = '0, ki = '0, kd = '0;
  logic               integ_clear = 1'b0, integ_hold = 1'b0;

  logic               os0, os1, os2;
  logic signed [39:0] po0, po1;
  logic signed [23:0] po2;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  pid_error_core dut (
    .clock(clock), .reset_n(reset_n), .in_strobe(in_strobe), .sample(sample),
    .setpoint(setpoint), .kp(kp), .ki(ki), .kd(kd), .integ_clear(integ_clear),
    .integ_hold(integ_hold), .out_strobe(os0), .pid_out(po0));

  pid_error_core #(.ACC_WIDTH(20)) dut_a20 (
    .clock(clock), .reset_n(reset_n), .in_strobe(in_strobe), .sample(sample),
    .setpoint(setpoint), .kp(kp), .ki(ki), .kd(kd), .integ_clear(integ_clear),
    .integ_hold(integ_hold), .out_strobe(os1), .pid_out(po1));

  pid_error_core #(.OUT_WIDTH(24)) dut_o24 (
    .clock(clock), .reset_n(reset_n), .in_strobe(in_strobe), .sample(sample),
    .setpoint(setpoint), .kp(kp), .ki(ki), .kd(kd), .integ_clear(integ_clear),
    .integ_hold(integ_hold), .out_strobe(os2), .pid_out(po2));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_strobe = 0; integ_clear = 0; integ_hold = 0;
    sample = 0; setpoint = 0; kp = 0; ki = 0; kd = 0;
  endtask

  task automatic apply_reset();
    reset_n = 0;
    idle_inputs();
    step(); step();
    reset_n = 1;
    step();
  endtask

  task automatic test_reset();
    reset_n = 0;
    for (int i = 0; i < 6; i++) begin
      in_strobe = 1'($urandom); integ_clear = 1'($urandom); integ_hold = 1'($urandom);
      sample = 16'($urandom); setpoint = 16'($urandom);
      kp = 16'($urandom); ki = 16'($urandom); kd = 16'($urandom);
      step();
      checks++;
      if ({os0, os1, os2} !== 3'b000 || po0 !== 40'sd0 || po1 !== 40'sd0 || po2 !== 24'sd0) begin
        errors++;
        $display("FAIL reset_hold: strobes=%b pid_out=%0d/%0d/%0d, required all 0", {os0, os1, os2}, po0, po1, po2);
      end
    end
    idle_inputs();
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({os0, os1, os2} !== 3'b000 || po0 !== 40'sd0 || po1 !== 40'sd0 || po2 !== 24'sd0) begin
        errors++;
        $display("FAIL reset_release: strobes=%b pid_out=%0d/%0d/%0d, required all 0", {os0, os1, os2}, po0, po1, po2);
      end
    end
  endtask

  task automatic test_proportional();
    apply_reset();
    kp = 2; setpoint = 100; sample = 40; in_strobe = 1;
    step();
    in_strobe = 0; kp = 7; setpoint = -300;
    step();
    checks++;
    if (os0 !== 1'b0) begin
      errors++; $display("FAIL prop_early: out_strobe=%b at N+2, required 0", os0);
    end
    step();
    checks++;
    if (os0 !== 1'b1 || po0 !== 40'sd120) begin
      errors++; $display("FAIL prop_result: out_strobe=%b pid_out=%0d at N+3, required 1 and 120", os0, po0);
    end
    step();
    checks++;
    if (os0 !== 1'b0) begin
      errors++; $display("FAIL prop_pulse: out_strobe=%b at N+4, required 0", os0);
    end
    step(); step();
    checks++;
    if (po0 !== 40'sd120) begin
      errors++; $display("FAIL prop_hold: pid_out=%0d after gain change without strobe, required 120", po0);
    end
  endtask

  task automatic test_integrator();
    apply_reset();
    ki = 1; setpoint = 15; sample = 5;
    for (int s = 1; s <= 6; s++) begin
      in_strobe = (s <= 4);
      step();
      if (s >= 3) begin
        checks++;
        if (os0 !== 1'b1 || po0 !== 40'(10 * (s - 2))) begin
          errors++;
          $display("FAIL integ_run%0d: out_strobe=%b pid_out=%0d, required 1 and %0d", s - 2, os0, po0, 10 * (s - 2));
        end
      end
    end
    in_strobe = 1; integ_hold = 1;
    step();
    in_strobe = 0; integ_hold = 0;
    step(); step();
    checks++;
    if (os0 !== 1'b1 || po0 !== 40'sd40) begin
      errors++; $display("FAIL integ_hold: out_strobe=%b pid_out=%0d, required 1 and 40", os0, po0);
    end
  endtask

  task automatic test_derivative();
    apply_reset();
    kd = 3; setpoint = 0; sample = -5; in_strobe = 1;
    step();
    sample = -12;
    step();
    in_strobe = 0;
    step();
    checks++;
    if (os0 !== 1'b1 || po0 !== 40'sd15) begin
      errors++; $display("FAIL deriv_first: out_strobe=%b pid_out=%0d, required 1 and 15", os0, po0);
    end
    step();
    checks++;
    if (os0 !== 1'b1 || po0 !== 40'sd21) begin
      errors++; $display("FAIL deriv_second: out_strobe=%b pid_out=%0d, required 1 and 21", os0, po0);
    end
  endtask

  task automatic test_setpoint_step();
    longint exp_kick;
`ifdef PID_DERIV_ON_MEAS_EN
    exp_kick = 0;
`else
    exp_kick = 150;
`endif
    apply_reset();
    kd = 3; sample = 0; setpoint = 0; in_strobe = 1;
    step();
    setpoint = 50;
    step();
    in_strobe = 0;
    step();
    checks++;
    if (os0 !== 1'b1 || po0 !== 40'sd0) begin
      errors++; $display("FAIL step_before: out_strobe=%b pid_out=%0d, required 1 and 0", os0, po0);
    end
    step();
    checks++;
    if (os0 !== 1'b1 || po0 !== exp_kick) begin
      errors++; $display("FAIL step_kick: out_strobe=%b pid_out=%0d, required 1 and %0d", os0, po0, exp_kick);
    end
  endtask

  task automatic test_clear_keeps_prev();
    apply_reset();
    ki = 1; kd = 1; setpoint = 0; sample = -5; in_strobe = 1;
    step();
    in_strobe = 0; integ_clear = 1;
    step();
    integ_clear = 0;
    step();
    checks++;
    if (os0 !== 1'b1 || po0 !== 40'sd10) begin
      errors++; $display("FAIL clear_first: out_strobe=%b pid_out=%0d, required 1 and 10", os0, po0);
    end
    in_strobe = 1;
    step();
    in_strobe = 0;
    step(); step();
    checks++;
    if (os0 !== 1'b1 || po0 !== 40'sd5) begin
      errors++; $display("FAIL clear_prev_kept: out_strobe=%b pid_out=%0d, required 1 and 5", os0, po0);
    end
  endtask

  task automatic test_acc_clamp();
    longint exp_v;
    apply_reset();
    ki = 1; setpoint = 32767; sample = 0;
    for (int s = 1; s <= 22; s++) begin
      in_strobe = (s <= 20);
      step();
      if (s >= 3) begin
        exp_v = longint'(s - 2) * 32767;
        if (exp_v > 524287) exp_v = 524287;
        checks++;
        if (os1 !== 1'b1 || po1 !== exp_v) begin
          errors++;
          $display("FAIL acc_clamp%0d: out_strobe=%b pid_out=%0d, required 1 and %0d", s - 2, os1, po1, exp_v);
        end
      end
    end
    in_strobe = 1; integ_clear = 1;
    step();
    in_strobe = 0; integ_clear = 0;
    step(); step();
    checks++;
    if (os1 !== 1'b1 || po1 !== 40'sd0) begin
      errors++; $display("FAIL acc_clear: out_strobe=%b pid_out=%0d, required 1 and 0", os1, po1);
    end
  endtask

  task automatic test_out_saturation();
    apply_reset();
    kp = 32767; setpoint = 32767; sample = -32768; in_strobe = 1;
    step();
    kp = -32768;
    step();
    in_strobe = 0;
    step();
    checks++;
    if (os2 !== 1'b1 || po2 !== 24'sd8388607) begin
      errors++; $display("FAIL sat_pos: out_strobe=%b pid_out=%0d, required 1 and 8388607", os2, po2);
    end
    checks++;
    if (po0 !== 40'sd2147385345) begin
      errors++; $display("FAIL wide_pos: pid_out=%0d, required 2147385345", po0);
    end
    step();
    checks++;
    if (os2 !== 1'b1 || po2 !== -24'sd8388608) begin
      errors++; $display("FAIL sat_neg: out_strobe=%b pid_out=%0d, required 1 and -8388608", os2, po2);
    end
    checks++;
    if (po0 !== -40'sd2147450880) begin
      errors++; $display("FAIL wide_neg: pid_out=%0d, required -2147450880", po0);
    end
  endtask

  task automatic test_midpipe_reset();
    int seen;
    apply_reset();
    kp = 2; setpoint = 100; sample = 40; in_strobe = 1;
    step();
    step();
    in_strobe = 0;
    step();
    reset_n = 0;
    step(); step();
    reset_n = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (os0 !== 1'b0 || po0 !== 40'sd0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midpipe_reset: %0d cycles with out_strobe/pid_out nonzero after release, required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_proportional();
    test_integrator();
    test_derivative();
    test_setpoint_step();
    test_clear_keeps_prev();
    test_acc_clamp();
    test_out_saturation();
    test_midpipe_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
